// File: rtl/rad4_quotient_recover.sv
// Iterative signed divider that recovers q = trunc((p << FRAC) / y) from a
// fixed-point product, one quotient bit per cycle, with saturation and divide-by-zero flags.
module rad4_quotient_recover #(
    parameter int FRAC = 10,
    parameter int PW   = 32,
    parameter int YW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] p,
    input  logic [YW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] q,
    output logic [YW-1:0] rem,
    output logic          ovf,
    output logic          dz,
    output logic [2:0]    dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // out_valid and the result fields hold steady until that edge, in_ready is high only in IDLE.

    localparam int NW = PW + FRAC;
    localparam int CW = $clog2(NW);
    localparam logic [PW-1:0] Q_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] Q_MIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [YW-1:0] y_q, y_d;
    logic [NW-1:0] n_q, n_d;
    logic [YW-1:0] ymag_q, ymag_d;
    logic          neg_q_q, neg_q_d;
    logic          neg_r_q, neg_r_d;
    logic [YW-1:0] pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] q_q, q_d;
    logic [YW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;
    logic          dz_q, dz_d;

    logic [YW:0]      pr_shift;
    logic [PW-1:0]    p_abs;
    logic [NW-PW:0]   q_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            ymag_q  <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            pr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            y_q     <= y_d;
            n_q     <= n_d;
            ymag_q  <= ymag_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        y_d      = y_q;
        n_d      = n_q;
        ymag_d   = ymag_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        pr_d     = pr_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        pr_shift = {pr_q, n_q[NW-1]};
        p_abs    = p_q[PW-1] ? -p_q : p_q;
        // n_q holds |N| on entry to ITER and is shifted out MSB-first while Q shifts in.
        q_hi     = n_q[NW-1:PW-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    p_d     = p;
                    y_d     = y;
                    state_d = PREP;
                end
            end
            PREP: begin
                n_d     = {p_abs, {FRAC{1'b0}}};
                ymag_d  = y_q[YW-1] ? -y_q : y_q;
                neg_q_d = p_q[PW-1] ^ y_q[YW-1];
                neg_r_d = p_q[PW-1];
                pr_d    = '0;
                cnt_d   = '0;
                state_d = (y_q == '0) ? FIX : ITER;
            end
            ITER: begin
                if (pr_shift >= {1'b0, ymag_q}) begin
                    pr_d = YW'(pr_shift - {1'b0, ymag_q});
                    n_d  = {n_q[NW-2:0], 1'b1};
                end else begin
                    pr_d = pr_shift[YW-1:0];
                    n_d  = {n_q[NW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NW-1)) state_d = FIX;
            end
            FIX: begin
                if (ymag_q == '0) begin
                    q_d   = p_q[PW-1] ? Q_MIN : Q_MAX;
                    rem_d = '0;
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else begin
                    dz_d  = 1'b0;
                    rem_d = neg_r_q ? -pr_q : pr_q;
                    if (neg_q_q) begin
                        // -2^31 is representable, so only magnitudes above 2^31 saturate.
                        ovf_d = (q_hi > 1) || ((q_hi == 1) && (|n_q[PW-2:0]));
                        q_d   = ovf_d ? Q_MIN : -n_q[PW-1:0];
                    end else begin
                        ovf_d = |q_hi;
                        q_d   = ovf_d ? Q_MAX : n_q[PW-1:0];
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == DONE);
    assign q           = q_q;
    assign rem         = rem_q;
    assign ovf         = ovf_q;
    assign dz          = dz_q;
    assign dbg_state_o = state_q;

endmodule
